// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with write bypass, busy scoreboard and clear sweep
module reg_file_mp #(
  parameter int p_WORD_LEN      = 16,
  parameter int p_REG_ADDR_LEN  = 3,
  parameter int p_REG_FILE_SIZE = 8,
  parameter int p_RD_PORTS      = 2,
  parameter int p_WR_PORTS      = 1,
  parameter int p_BYPASS        = 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [p_RD_PORTS*p_REG_ADDR_LEN-1:0] i_rd_addr,
  output logic [p_RD_PORTS*p_WORD_LEN-1:0]     o_rd_data,
  output logic [p_RD_PORTS-1:0]                o_rd_busy,
  input  logic [p_WR_PORTS-1:0]                i_wr_en,
  input  logic [p_WR_PORTS*p_REG_ADDR_LEN-1:0] i_wr_addr,
  input  logic [p_WR_PORTS*p_WORD_LEN-1:0]     i_wr_data,
  input  logic                                 i_rsv_en,
  input  logic [p_REG_ADDR_LEN-1:0]            i_rsv_addr,
  output logic [p_REG_FILE_SIZE-1:0]           o_busy_vec,
  output logic                                 o_ready
);
  localparam int AW = p_REG_ADDR_LEN;
  localparam int W  = p_WORD_LEN;
  localparam int N  = p_REG_FILE_SIZE;

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [N-1:0]  busy_q, busy_d;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;
  logic [W-1:0]  rd_word;
  logic          rd_b;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    wa      = '0;
    if (state_q == S_CLEAR) begin
      mem_d[idx_q] = '0;
      idx_d        = idx_q + AW'(1);
      if (idx_q == AW'(N - 1)) state_d = S_RUN;
    end else begin
      // Ascending port order lets the highest-indexed writer win a collision.
      for (int j = 0; j < p_WR_PORTS; j++) begin
        wa = i_wr_addr[j*AW +: AW];
        if (i_wr_en[j] && wa != '0) begin
          mem_d[wa]  = i_wr_data[j*W +: W];
          busy_d[wa] = 1'b0;
        end
      end
      // Reservation applied after writeback: the new producer owns the register.
      if (i_rsv_en && i_rsv_addr != '0) busy_d[i_rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_CLEAR;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) mem_q <= mem_d;
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    ra        = '0;
    rd_word   = '0;
    rd_b      = 1'b0;
    if (state_q == S_RUN) begin
      for (int k = 0; k < p_RD_PORTS; k++) begin
        ra      = i_rd_addr[k*AW +: AW];
        rd_word = (ra == '0) ? '0 : mem_q[ra];
        rd_b    = busy_q[ra];
        if (p_BYPASS != 0 && ra != '0) begin
          for (int j = 0; j < p_WR_PORTS; j++) begin
            if (i_wr_en[j] && i_wr_addr[j*AW +: AW] == ra) begin
              rd_word = i_wr_data[j*W +: W];
              rd_b    = 1'b0;
            end
          end
        end
        o_rd_data[k*W +: W] = rd_word;
        o_rd_busy[k]        = rd_b;
      end
    end
  end

  assign o_busy_vec = busy_q;
  assign o_ready    = (state_q == S_RUN);

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed and model-based checks of reg_file_mp (bypass and non-bypass builds)
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [8:0]  rd_addr;
  logic [47:0] rd_data;
  logic [2:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [2:0]  rsv_addr;
  logic [7:0]  busy_vec;
  logic        ready;

  logic [5:0]  b_rd_addr;
  logic [31:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [0:0]  b_wr_en;
  logic [2:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic        b_rsv_en;
  logic [2:0]  b_rsv_addr;
  logic [7:0]  b_busy_vec;
  logic        b_ready;

  reg_file_mp #(.p_RD_PORTS(3), .p_WR_PORTS(2), .p_BYPASS(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_busy(rd_busy),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rsv_en(rsv_en),
    .i_rsv_addr(rsv_addr), .o_busy_vec(busy_vec), .o_ready(ready)
  );

  reg_file_mp #(.p_RD_PORTS(2), .p_WR_PORTS(1), .p_BYPASS(0)) u_dut_nb (
    .i_clk(clk), .i_rst(rst), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data), .o_rd_busy(b_rd_busy),
    .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .i_rsv_en(b_rsv_en),
    .i_rsv_addr(b_rsv_addr), .o_busy_vec(b_busy_vec), .o_ready(b_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] ref_mem [8];
  logic [7:0]  ref_busy;
  logic [47:0] exp_data;
  logic [2:0]  exp_busy;
  logic [2:0]  ma;
  logic [15:0] md;
  logic        mb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rsv_en = 1'b0; b_rsv_addr = '0; b_rd_addr = '0;
  endtask

  task automatic rd_all(input logic [2:0] a);
    rd_addr   = {a, a, a};
    b_rd_addr = {a, a};
  endtask

  task automatic wr(input int port, input logic [2:0] a, input logic [15:0] d);
    wr_en[port]             = 1'b1;
    wr_addr[port*3 +: 3]    = a;
    wr_data[port*16 +: 16]  = d;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    next();
    rst = 1'b0;

    // Clear sweep: ready low exactly 8 cycles, outputs quiet meanwhile
    for (int i = 0; i < 8; i++) begin
      sample();
      check("t1_ready_low", ready, 1'b0);
      check("t1_busyvec_rst", busy_vec, 8'h00);
      check("t1_rd_quiet", rd_data, 48'h0);
      next();
    end
    sample();
    check("t1_ready_high", ready, 1'b1);
    check("t1_nb_ready_high", b_ready, 1'b1);
    for (int r = 0; r < 8; r++) begin
      rd_all(3'(r));
      sample();
      check("t1_rd_cleared", rd_data, 48'h0);
      check("t1_nb_rd_cleared", b_rd_data, 32'h0);
      next();
    end

    // Same-cycle write/read: bypass vs array-only
    idle();
    wr(0, 3'd3, 16'hBEEF);
    b_wr_en = 1'b1; b_wr_addr = 3'd3; b_wr_data = 16'hBEEF;
    rd_all(3'd3);
    sample();
    check("t2_bypass", rd_data, {3{16'hBEEF}});
    check("t2_bypass_busy", rd_busy, 3'b000);
    check("t2_nb_old", b_rd_data, 32'h0);
    next();
    idle();
    rd_all(3'd3);
    sample();
    check("t2_after", rd_data, {3{16'hBEEF}});
    check("t2_nb_after", b_rd_data, {2{16'hBEEF}});
    next();

    // Write collision and register 0
    idle();
    wr(0, 3'd5, 16'h1111);
    wr(1, 3'd5, 16'h2222);
    rd_all(3'd5);
    sample();
    check("t3_collide_bypass", rd_data, {3{16'h2222}});
    next();
    idle();
    rd_all(3'd5);
    sample();
    check("t3_collide_array", rd_data, {3{16'h2222}});
    next();
    idle();
    wr(0, 3'd0, 16'hFFFF);
    rd_all(3'd0);
    sample();
    check("t3_r0_bypass", rd_data, 48'h0);
    next();
    idle();
    rd_addr = {3'd5, 3'd3, 3'd0};
    sample();
    check("t3_mixed_ports", rd_data, {16'h2222, 16'hBEEF, 16'h0000});
    next();

    // Scoreboard
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd4;
    rd_all(3'd4);
    sample();
    check("t4_rsv_not_yet", busy_vec, 8'h00);
    check("t4_rdbusy_not_yet", rd_busy, 3'b000);
    next();
    idle();
    rd_all(3'd4);
    sample();
    check("t4_busy_set", busy_vec, 8'h10);
    check("t4_rdbusy_set", rd_busy, 3'b111);
    next();
    idle();
    wr(1, 3'd4, 16'h4444);
    rd_all(3'd4);
    sample();
    check("t4_wb_rdbusy_bypass", rd_busy, 3'b000);
    check("t4_wb_busy_still", busy_vec, 8'h10);
    check("t4_wb_data", rd_data, {3{16'h4444}});
    next();
    idle();
    rd_all(3'd4);
    sample();
    check("t4_busy_cleared", busy_vec, 8'h00);
    next();
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd4;
    wr(0, 3'd4, 16'h5555);
    next();
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd0;
    rd_all(3'd4);
    sample();
    check("t4_rsv_wr_same", busy_vec, 8'h10);
    check("t4_rsv_wr_rdbusy", rd_busy, 3'b111);
    check("t4_rsv_wr_data", rd_data, {3{16'h5555}});
    next();
    idle();
    rsv_en = 1'b1; rsv_addr = 3'd4;
    sample();
    check("t4_r0_never_busy", busy_vec, 8'h10);
    next();
    idle();
    sample();
    check("t4_rsv_again", busy_vec, 8'h10);
    next();

    // Reset mid-sweep restarts the clear
    idle();
    wr(0, 3'd2, 16'h00AA);
    next();
    idle();
    rd_all(3'd2);
    sample();
    check("t5_r2_written", rd_data, {3{16'h00AA}});
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    wr(0, 3'd2, 16'h5555);
    rsv_en = 1'b1; rsv_addr = 3'd6;
    rd_all(3'd2);
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t5_ready_low_a", ready, 1'b0);
      check("t5_busyvec_a", busy_vec, 8'h00);
      next();
    end
    rst = 1'b1;
    next();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sample();
      check("t5_ready_low_b", ready, 1'b0);
      check("t5_rd_quiet", rd_data, 48'h0);
      next();
    end
    idle();
    rd_all(3'd2);
    sample();
    check("t5_ready_high", ready, 1'b1);
    check("t5_r2_cleared", rd_data, 48'h0);
    check("t5_busyvec_clear", busy_vec, 8'h00);
    next();

    // Random traffic against a reference model
    for (int i = 0; i < 8; i++) ref_mem[i] = 16'h0;
    ref_busy = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      idle();
      wr_en    = 2'($urandom);
      wr_addr  = 6'($urandom);
      wr_data  = $urandom;
      rsv_en   = 1'($urandom);
      rsv_addr = 3'($urandom);
      rd_addr  = 9'($urandom);
      for (int k = 0; k < 3; k++) begin
        ma = rd_addr[k*3 +: 3];
        md = (ma == 3'd0) ? 16'h0 : ref_mem[ma];
        mb = ref_busy[ma];
        for (int j = 0; j < 2; j++) begin
          if (wr_en[j] && wr_addr[j*3 +: 3] == ma && ma != 3'd0) begin
            md = wr_data[j*16 +: 16];
            mb = 1'b0;
          end
        end
        exp_data[k*16 +: 16] = md;
        exp_busy[k]          = mb;
      end
      sample();
      check("t6_rd_data", rd_data, exp_data);
      check("t6_rd_busy", rd_busy, exp_busy);
      check("t6_busy_vec", busy_vec, ref_busy);
      for (int j = 0; j < 2; j++) begin
        ma = wr_addr[j*3 +: 3];
        if (wr_en[j] && ma != 3'd0) begin
          ref_mem[ma]  = wr_data[j*16 +: 16];
          ref_busy[ma] = 1'b0;
        end
      end
      if (rsv_en && rsv_addr != 3'd0) ref_busy[rsv_addr] = 1'b1;
      next();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
